scaler_hctrl: RTL

SCALER_HCTRL -- requirements
Module: scaler_hctrl

---
 rtl/scaler_hctrl_defs.sv | 16 +
 rtl/scaler_hctrl_coef_ram.sv | 54 +++++
 rtl/scaler_hctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/scaler_hctrl_defs.sv
// scaler_hctrl shared definitions: FSM states and
// position accumulator geometry (Q4.16 step, 28-bit pos).
package scaler_hctrl_defs;

  localparam int FRAC_W = 16;
  localparam int ACC_W  = 28;
  localparam int INT_W  = ACC_W - FRAC_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/scaler_hctrl_coef_ram.sv
// Phase-indexed coefficient table: sync write, comb read.
// SCALER_HCTRL_COEF_INIT_EN: reset loads a bilinear table.
module scaler_hctrl_coef_ram #(
  parameter int PHASE_BITS = 5,
  parameter int CW         = 8,
  parameter int KN         = 4
) (
  input  logic                  clk,
`ifdef SCALER_HCTRL_COEF_INIT_EN
  input  logic                  rst,
`endif
  input  logic                  we,
  input  logic [PHASE_BITS-1:0] waddr,
  input  logic [CW*KN-1:0]      wdata,
  input  logic [PHASE_BITS-1:0] raddr,
  output logic [CW*KN-1:0]      rdata
);

  localparam int DEPTH = 2 ** PHASE_BITS;

  logic [CW*KN-1:0] mem_q [DEPTH];

`ifdef SCALER_HCTRL_COEF_INIT_EN
  // Bilinear row: weight splits between the two centre taps.
  function automatic logic [CW*KN-1:0] bilin(input int p);
    logic [CW*KN-1:0] r;
    r = '0;
    r[CW*1 +: CW] = CW'(64 - 2 * p);
    r[CW*2 +: CW] = CW'(2 * p);
    return r;
  endfunction

  // Table write, or bilinear preload on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < DEPTH; p++) begin
        mem_q[p] <= bilin(p);
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end
`else
  // Table write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end
`endif

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/scaler_hctrl.sv
// Horizontal scaler control: window fetch, phase step, DSP feed.
// SCALER_HCTRL_COEF_INIT_EN: bilinear coefficient preload on reset.
module scaler_hctrl
  import scaler_hctrl_defs::*;
#(
  parameter int KERNEL_MAX           = 4,
  parameter int KERNEL_COEF_BITWIDTH = 8,
  parameter int VRLT_BITWIDTH        = 18,
  parameter int PHASE_BITS           = 5,
  parameter int WIDTH_BITS           = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH_BITS-1:0]     cfg_src_w,
  input  logic [WIDTH_BITS-1:0]     cfg_dst_w,
  input  logic [19:0]               cfg_step,
  input  logic                      start,
  output logic                      busy,
  output logic                      line_done,
  output logic                      cfg_err,
  input  logic                      coef_we,
  input  logic [PHASE_BITS-1:0]     coef_addr,
  input  logic [KERNEL_COEF_BITWIDTH*KERNEL_MAX-1:0] coef_wdata,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [VRLT_BITWIDTH-1:0]  s_data,
  output logic                      dsp_en,
  output logic [KERNEL_COEF_BITWIDTH*KERNEL_MAX-1:0] dsp_coef,
  output logic [VRLT_BITWIDTH*KERNEL_MAX-1:0] dsp_vrlt
);

  localparam int CW = KERNEL_COEF_BITWIDTH * KERNEL_MAX;
  localparam int VW = VRLT_BITWIDTH;
  localparam int KW = $clog2(KERNEL_MAX + 1);
  localparam int EW = INT_W + 1;

  state_e                 state_q;
  logic [WIDTH_BITS-1:0]  src_w_q, dst_w_q;
  logic [WIDTH_BITS-1:0]  acc_cnt_q, out_cnt_q;
  logic [19:0]            step_q;
  logic [ACC_W-1:0]       pos_q;
  logic [INT_W-1:0]       b_q;
  logic [KW-1:0]          cnt_q;
  logic [VW-1:0]          win_q [KERNEL_MAX];
  logic [VW-1:0]          last_q;
  logic                   busy_q, line_done_q, cfg_err_q, dsp_en_q;
  logic [CW-1:0]          dsp_coef_q;
  logic [VW*KERNEL_MAX-1:0] dsp_vrlt_q;

  logic [INT_W-1:0]       n;
  logic [PHASE_BITS-1:0]  phase;
  logic [EW-1:0]          e;
  logic                   full, need_px, want_app, do_app, issue, cfg_bad;
  logic [VW-1:0]          new_px;
  logic [CW-1:0]          coef_rd;
  logic [VW*KERNEL_MAX-1:0] win_flat;

  assign n     = pos_q[ACC_W-1:FRAC_W];
  assign phase = pos_q[FRAC_W-1 -: PHASE_BITS];
  assign full  = cnt_q == KW'(KERNEL_MAX);
  // e: padded-stream index of the next entry to append
  assign e     = {1'b0, b_q} + EW'(cnt_q);
  // E[0] fetches p0; E[1] and right pads reuse the last pixel
  assign need_px = (e == '0) ||
                   (e >= EW'(2) && e <= EW'(src_w_q));
  assign want_app = (state_q == S_RUN) && (!full || b_q < n);
  assign do_app   = want_app && (!need_px || s_valid);
  assign new_px   = need_px ? s_data : last_q;
  assign issue    = (state_q == S_RUN) && full && (b_q == n);
  assign cfg_bad  = (cfg_step == '0) || (cfg_src_w == '0) ||
                    (cfg_dst_w == '0);

  assign s_ready = (want_app && need_px) || (state_q == S_DRAIN);

  // Flatten the window into DSP lane order.
  always_comb begin
    win_flat = '0;
    for (int t = 0; t < KERNEL_MAX; t++) begin
      win_flat[t*VW +: VW] = win_q[t];
    end
  end

  scaler_hctrl_coef_ram #(
    .PHASE_BITS (PHASE_BITS),
    .CW         (KERNEL_COEF_BITWIDTH),
    .KN         (KERNEL_MAX)
  ) u_coef (
    .clk   (clk),
`ifdef SCALER_HCTRL_COEF_INIT_EN
    .rst   (rst),
`endif
    .we    (coef_we && !busy_q),
    .waddr (coef_addr),
    .wdata (coef_wdata),
    .raddr (phase),
    .rdata (coef_rd)
  );

  // Line FSM with window, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      src_w_q     <= '0;
      dst_w_q     <= '0;
      step_q      <= '0;
      acc_cnt_q   <= '0;
      out_cnt_q   <= '0;
      pos_q       <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      last_q      <= '0;
      busy_q      <= 1'b0;
      line_done_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      dsp_en_q    <= 1'b0;
      dsp_coef_q  <= '0;
      dsp_vrlt_q  <= '0;
      for (int i = 0; i < KERNEL_MAX; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      line_done_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      dsp_en_q    <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start && cfg_bad) begin
            cfg_err_q <= 1'b1;
          end else if (start) begin
            src_w_q   <= cfg_src_w;
            dst_w_q   <= cfg_dst_w;
            step_q    <= cfg_step;
            acc_cnt_q <= '0;
            out_cnt_q <= '0;
            pos_q     <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          if (do_app) begin
            if (need_px) begin
              acc_cnt_q <= acc_cnt_q + 1'b1;
              last_q    <= s_data;
            end
            if (full) begin
              for (int i = 0; i < KERNEL_MAX - 1; i++) begin
                win_q[i] <= win_q[i+1];
              end
              win_q[KERNEL_MAX-1] <= new_px;
              b_q <= b_q + 1'b1;
            end else begin
              for (int i = 0; i < KERNEL_MAX; i++) begin
                if (KW'(i) == cnt_q) begin
                  win_q[i] <= new_px;
                end
              end
              cnt_q <= cnt_q + 1'b1;
            end
          end
          if (issue) begin
            dsp_en_q   <= 1'b1;
            dsp_coef_q <= coef_rd;
            dsp_vrlt_q <= win_flat;
            pos_q      <= pos_q + ACC_W'(step_q);
            out_cnt_q  <= out_cnt_q + 1'b1;
            if (out_cnt_q + 1'b1 == dst_w_q) begin
              if (acc_cnt_q < src_w_q) begin
                state_q <= S_DRAIN;
              end else begin
                state_q     <= S_DONE;
                line_done_q <= 1'b1;
              end
            end
          end
        end
        S_DRAIN: begin
          if (s_valid) begin
            acc_cnt_q <= acc_cnt_q + 1'b1;
            if (acc_cnt_q + 1'b1 == src_w_q) begin
              state_q     <= S_DONE;
              line_done_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign line_done = line_done_q;
  assign cfg_err   = cfg_err_q;
  assign dsp_en    = dsp_en_q;
  assign dsp_coef  = dsp_coef_q;
  assign dsp_vrlt  = dsp_vrlt_q;

endmodule
